// File: rtl/timer_pkg.sv
// Shared definitions for the timer front end.
// Holds the per-channel button state enum and the button index constants
// that name each bit of the button bus (start, stop, delete, incSec, incMin).
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    REL_DB   = 2'd3
  } chan_state_e;

  localparam int BTN_START   = 0;
  localparam int BTN_STOP    = 1;
  localparam int BTN_DELETE  = 2;
  localparam int BTN_INC_SEC = 3;
  localparam int BTN_INC_MIN = 4;

endpackage

// File: rtl/button_channel.sv
// One button channel: two-flop synchroniser, debounce FSM, auto-repeat timer.
// Ports:
//   i_clk        clock
//   i_rst        synchronous active-high reset
//   i_button     raw asynchronous button level
//   o_level      debounced level (registered)
//   o_press      one-cycle press / repeat pulse (registered)
//   o_press_nxt  value o_press takes at the next edge, so the top can
//                register an aggregate in step with o_press
module button_channel
  import timer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter bit REPEAT_EN       = 1'b0,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_PERIOD   = 5_000_000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_button,
  output logic o_level,
  output logic o_press,
  output logic o_press_nxt
);

  localparam int CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_TGT   = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [RPT_W-1:0] RPT_DELAY = RPT_W'(REPEAT_DELAY);
  localparam logic [RPT_W-1:0] RPT_PER   = RPT_W'(REPEAT_PERIOD);
  // With a one-sample debounce the first qualifying sample already completes it.
  localparam bit               DB_ONE    = (DEBOUNCE_CYCLES <= 1);

  logic [1:0]       r_sync;
  chan_state_e      r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [RPT_W-1:0] r_rpt;
  logic             r_repeating;
  logic             r_level;
  logic             r_press;

  chan_state_e      w_next_state;
  logic [CNT_W-1:0] w_cnt_nxt, w_cnt_inc;
  logic [RPT_W-1:0] w_rpt_nxt, w_rpt_inc, w_rpt_tgt;
  logic             w_rep_nxt, w_rpt_hit;
  logic             w_level_nxt, w_press_nxt;
  logic             w_sample;

  assign w_sample  = r_sync[1];
  // Counters saturate rather than wrap.
  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
  assign w_rpt_inc = (r_rpt == '1) ? r_rpt : r_rpt + 1'b1;
  assign w_rpt_tgt = r_repeating ? RPT_PER : RPT_DELAY;
  assign w_rpt_hit = REPEAT_EN && (w_rpt_inc == w_rpt_tgt);

  // Next-state and counter update.
  always_comb begin
    w_next_state = r_state;
    w_cnt_nxt    = r_cnt;
    w_rpt_nxt    = r_rpt;
    w_rep_nxt    = r_repeating;
    unique case (r_state)
      IDLE: begin
        if (w_sample) begin
          if (DB_ONE) begin
            w_next_state = HELD;
            w_cnt_nxt    = '0;
            w_rpt_nxt    = '0;
            w_rep_nxt    = 1'b0;
          end else begin
            w_next_state = PRESS_DB;
            w_cnt_nxt    = CNT_W'(1);
          end
        end
      end
      PRESS_DB: begin
        if (!w_sample) begin
          w_next_state = IDLE;
          w_cnt_nxt    = '0;
        end else if (w_cnt_inc == CNT_TGT) begin
          w_next_state = HELD;
          w_cnt_nxt    = '0;
          w_rpt_nxt    = '0;
          w_rep_nxt    = 1'b0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      HELD: begin
        // A release sample takes priority over a repeat due the same cycle.
        if (!w_sample) begin
          w_next_state = DB_ONE ? IDLE : REL_DB;
          w_cnt_nxt    = DB_ONE ? '0 : CNT_W'(1);
        end else if (REPEAT_EN) begin
          if (w_rpt_hit) begin
            w_rpt_nxt = '0;
            w_rep_nxt = 1'b1;
          end else begin
            w_rpt_nxt = w_rpt_inc;
          end
        end
      end
      REL_DB: begin
        // rpt_cnt / repeating untouched so a bounce resumes the schedule.
        if (w_sample) begin
          w_next_state = HELD;
          w_cnt_nxt    = '0;
        end else if (w_cnt_inc == CNT_TGT) begin
          w_next_state = IDLE;
          w_cnt_nxt    = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Output decode, registered below.
  always_comb begin
    w_level_nxt = (w_next_state == HELD) || (w_next_state == REL_DB);
    w_press_nxt = ((r_state == IDLE || r_state == PRESS_DB) && w_next_state == HELD) ||
                  (r_state == HELD && w_next_state == HELD && w_rpt_hit);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync      <= '0;
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_rpt       <= '0;
      r_repeating <= 1'b0;
      r_level     <= 1'b0;
      r_press     <= 1'b0;
    end else begin
      r_sync      <= {r_sync[0], i_button};
      r_state     <= w_next_state;
      r_cnt       <= w_cnt_nxt;
      r_rpt       <= w_rpt_nxt;
      r_repeating <= w_rep_nxt;
      r_level     <= w_level_nxt;
      r_press     <= w_press_nxt;
    end
  end

  assign o_level     = r_level;
  assign o_press     = r_press;
  assign o_press_nxt = i_rst ? 1'b0 : w_press_nxt;

endmodule

// File: rtl/button_event_conditioner.sv
// Conditions the raw board buttons ahead of the timer FSM: per channel
// synchronise, debounce, press pulse and optional auto-repeat.
// Ports:
//   CLK_50MHZ  system clock
//   reset      synchronous active-high reset
//   button     raw asynchronous buttons (start, stop, delete, incSec, incMin)
//   level      debounced levels
//   press      one-cycle press / repeat pulses
//   any_press  OR of press, registered in the same cycle as press
module button_event_conditioner
  import timer_pkg::*;
#(
  parameter int                   N_BUTTONS       = 5,
  parameter int                   DEBOUNCE_CYCLES = 1_000_000,
  parameter logic [N_BUTTONS-1:0] REPEAT_MASK     = 5'b11000,
  parameter int                   REPEAT_DELAY    = 25_000_000,
  parameter int                   REPEAT_PERIOD   = 5_000_000
) (
  input  logic                 CLK_50MHZ,
  input  logic                 reset,
  input  logic [N_BUTTONS-1:0] button,
  output logic [N_BUTTONS-1:0] level,
  output logic [N_BUTTONS-1:0] press,
  output logic                 any_press
);

  logic [N_BUTTONS-1:0] w_press_nxt;
  logic                 r_any_press;

  for (genvar g = 0; g < N_BUTTONS; g++) begin : g_ch
    button_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_EN      (REPEAT_MASK[g]),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_ch (
      .i_clk      (CLK_50MHZ),
      .i_rst      (reset),
      .i_button   (button[g]),
      .o_level    (level[g]),
      .o_press    (press[g]),
      .o_press_nxt(w_press_nxt[g])
    );
  end

  // Built from the channels' next-press terms so it lands on the same edge.
  always_ff @(posedge CLK_50MHZ) begin
    if (reset) r_any_press <= 1'b0;
    else       r_any_press <= |w_press_nxt;
  end

  assign any_press = r_any_press;

endmodule

// File: tb/tb_button_event_conditioner.sv
module tb_button_event_conditioner;

  localparam int N   = 5;
  localparam int D   = 4;
  localparam int DLY = 10;
  localparam int PER = 3;
  localparam logic [N-1:0] MASK = 5'b11000;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] btn = '0;
  logic [N-1:0] level, press;
  logic         any_press;

  always #10 clk = ~clk;

  button_event_conditioner #(
    .N_BUTTONS(N), .DEBOUNCE_CYCLES(D), .REPEAT_MASK(MASK),
    .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER)
  ) dut (
    .CLK_50MHZ(clk), .reset(rst), .button(btn),
    .level(level), .press(press), .any_press(any_press)
  );

  typedef struct packed {
    logic [N-1:0] level;
    logic [N-1:0] press;
    logic         any;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Reference model: raw input reaches the decision logic two samples late;
  // a press needs D consecutive 1 samples, a release D consecutive 0 samples.
  // While held, every held-high sample counts toward the next repeat; samples
  // spent in a release bounce (and the one that ends it) do not count.
  logic [N-1:0] m_s1 = '0, m_s2 = '0, m_lvl = '0;
  int           m_run1[N], m_run0[N], m_ticks[N];
  bit           m_rep[N];

  task automatic model_edge(input logic [N-1:0] b, input logic r, output exp_t e);
    logic [N-1:0] p;
    bit samp;
    p = '0;
    if (r) begin
      m_s1 = '0; m_s2 = '0; m_lvl = '0;
      for (int i = 0; i < N; i++) begin
        m_run1[i] = 0; m_run0[i] = 0; m_ticks[i] = 0; m_rep[i] = 0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        samp = m_s2[i];
        if (!m_lvl[i]) begin
          if (samp) begin
            m_run1[i]++;
            if (m_run1[i] == D) begin
              m_lvl[i] = 1'b1; p[i] = 1'b1;
              m_ticks[i] = 0; m_rep[i] = 0; m_run0[i] = 0;
            end
          end else m_run1[i] = 0;
        end else begin
          if (!samp) begin
            m_run0[i]++;
            if (m_run0[i] == D) begin
              m_lvl[i] = 1'b0; m_run0[i] = 0; m_run1[i] = 0;
            end
          end else if (m_run0[i] != 0) begin
            m_run0[i] = 0;
          end else if (MASK[i]) begin
            m_ticks[i]++;
            if (m_ticks[i] == (m_rep[i] ? PER : DLY)) begin
              p[i] = 1'b1; m_rep[i] = 1; m_ticks[i] = 0;
            end
          end
        end
      end
      m_s2 = m_s1;
      m_s1 = b;
    end
    e.level = m_lvl;
    e.press = p;
    e.any   = |p;
  endtask

  task automatic step(input logic [N-1:0] b, input logic r);
    exp_t e;
    @(negedge clk);
    btn = b;
    rst = r;
    model_edge(b, r, e);
    q.push_back(e);
  endtask

  task automatic hold(input logic [N-1:0] b, input int n);
    for (int i = 0; i < n; i++) step(b, 1'b0);
  endtask

  // Monitor: one registered output set per edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if ({level, press, any_press} !== e) begin
          errors++;
          $display("FAIL outputs cyc %0d: got level=%b press=%b any=%b want level=%b press=%b any=%b",
                   cyc, level, press, any_press, e.level, e.press, e.any);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: got timeout want finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    logic [N-1:0] b;
    for (int i = 0; i < N; i++) begin
      m_run1[i] = 0; m_run0[i] = 0; m_ticks[i] = 0; m_rep[i] = 0;
    end
    repeat (3) step('0, 1'b1);

    // clean press, no repeat channel
    hold(5'b00001, 30); hold('0, 10);
    // bounce rejection
    for (int i = 0; i < 24; i++) step((i % 4 != 3) ? 5'b00010 : 5'b00000, 1'b0);
    hold('0, 6);
    // auto-repeat
    hold(5'b01000, 40); hold('0, 10);
    // release glitch while held
    hold(5'b10000, 20); hold('0, 2); hold(5'b10000, 15); hold('0, 10);
    // simultaneous
    hold(5'b00101, 10); hold('0, 10);
    // reset during press debounce
    hold(5'b00001, 3); step(5'b00001, 1'b1); step(5'b00001, 1'b1);
    hold(5'b00001, 15); hold('0, 10);
    // reset during repeat run
    hold(5'b01000, 25); step(5'b01000, 1'b1); step(5'b01000, 1'b1);
    hold(5'b01000, 20); hold('0, 10);

    // random toggling with occasional resets
    b = '0;
    for (int c = 0; c < 900; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(c < 450 ? 6 : 14) == 0) b[i] = ~b[i];
      step(b, $urandom_range(249) == 0);
    end
    hold('0, 10);

    repeat (3) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
